// File: rtl/seq_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decoder_if
//  Description : Signal bundle between the model-machine sequencer and the
//                rest of the controller/datapath.
//                Sequencer inputs : bus_in, alu_cf, alu_zf, cf_en, zf_en,
//                                   in_valid, out_ready
//                Sequencer outputs: ir, sm, op_hot, z, c, io_wait, halted,
//                                   io_timeout
//                modport master = sequencer side, modport slave = environment.
//  Revision    : 1.0 - initial release
// ============================================================================
interface seq_decoder_if;
  logic [7:0]  bus_in;      // RAM data bus, instruction byte in FETCH
  logic        alu_cf;      // ALU/shifter carry out
  logic        alu_zf;      // ALU zero result
  logic        cf_en;       // carry-flag load enable
  logic        zf_en;       // zero-flag load enable
  logic        in_valid;    // IN handshake: input device has data
  logic        out_ready;   // OUT handshake: output device can accept data

  logic [7:0]  ir;          // instruction register
  logic        sm;          // phase: 0 = FETCH, 1 = EXEC/HALTED
  logic [15:0] op_hot;      // one-hot instruction lines, index = ir[7:4]
  logic        z;           // zero flag
  logic        c;           // carry flag
  logic        io_wait;     // EXEC stalled on an I/O handshake
  logic        halted;      // HALT executed
  logic        io_timeout;  // sticky: an I/O handshake was abandoned

  modport master (
    input  bus_in, alu_cf, alu_zf, cf_en, zf_en, in_valid, out_ready,
    output ir, sm, op_hot, z, c, io_wait, halted, io_timeout
  );

  modport slave (
    output bus_in, alu_cf, alu_zf, cf_en, zf_en, in_valid, out_ready,
    input  ir, sm, op_hot, z, c, io_wait, halted, io_timeout
  );
endinterface
`default_nettype wire

// File: rtl/seq_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : seq_decoder
//  Description : Sequencing half of the model-machine controller. Runs the
//                FETCH/EXEC cycle, holds the instruction register and the
//                carry/zero flags, and emits the phase bit plus one-hot
//                instruction lines. IN/OUT stall on device handshakes with
//                an optional timeout; HALT latches until reset.
//  Ports       : clk   - system clock, rising edge
//                rst_n - synchronous active-low reset
//                bus   - seq_decoder_if.master (data bus, ALU flags, flag
//                        enables, I/O handshakes in; ir, sm, op_hot, flags,
//                        io_wait, halted, io_timeout out)
//  Parameters  : IO_TIMEOUT - max EXEC wait cycles on an I/O handshake,
//                             0 = wait forever (legal 0..65535)
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_decoder #(
  parameter int unsigned IO_TIMEOUT = 0
) (
  input  wire logic     clk,
  input  wire logic     rst_n,
  seq_decoder_if.master bus
);

  // --------------------------------------------------------------------------
  // Constants
  // --------------------------------------------------------------------------
  localparam logic [1:0] c_st_fetch  = 2'd0;
  localparam logic [1:0] c_st_exec   = 2'd1;
  localparam logic [1:0] c_st_halted = 2'd2;

  localparam logic [3:0] c_op_nop  = 4'h0;
  localparam logic [3:0] c_op_in   = 4'h1;
  localparam logic [3:0] c_op_out  = 4'h2;
  localparam logic [3:0] c_op_halt = 4'hF;

  localparam logic [15:0] c_timeout    = IO_TIMEOUT[15:0];
  localparam bit          c_timeout_en = (IO_TIMEOUT != 0);

  localparam logic [15:0] c_hot_nop  = 16'h0001;
  localparam logic [15:0] c_hot_halt = 16'h8000;

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  logic [1:0]  r_state;
  logic [7:0]  r_ir;
  logic        r_z;
  logic        r_c;
  logic        r_io_timeout;
  logic [15:0] r_wait_cnt;

  // --------------------------------------------------------------------------
  // Combinational signals
  // --------------------------------------------------------------------------
  logic [1:0]  w_state_next;
  logic [3:0]  w_opcode;
  logic        w_in_exec;
  logic        w_is_io;
  logic        w_hs_done;
  logic        w_timeout_hit;
  logic        w_issue;      // EXEC cycle that executes the instruction
  logic        w_abandon;    // EXEC cycle that gives up on an I/O handshake
  logic        w_stall;      // EXEC cycle that waits on an I/O handshake
  logic        w_sm;
  logic [15:0] w_op_hot;
  logic        w_io_wait;
  logic        w_halted;

  assign w_opcode  = r_ir[7:4];
  assign w_in_exec = (r_state == c_st_exec);
  assign w_is_io   = (w_opcode == c_op_in) || (w_opcode == c_op_out);

  // Only the handshake belonging to the current opcode matters.
  assign w_hs_done = ((w_opcode == c_op_in)  && bus.in_valid) ||
                     ((w_opcode == c_op_out) && bus.out_ready);

  // A completing handshake wins over the timeout in the same cycle.
  assign w_timeout_hit = c_timeout_en && (r_wait_cnt == c_timeout);

  assign w_issue   = w_in_exec && (!w_is_io || w_hs_done);
  assign w_abandon = w_in_exec && w_is_io && !w_hs_done && w_timeout_hit;
  assign w_stall   = w_in_exec && w_is_io && !w_hs_done && !w_timeout_hit;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= c_st_fetch;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_st_fetch: begin
        w_state_next = c_st_exec;
      end
      c_st_exec: begin
        if (w_issue) begin
          w_state_next = (w_opcode == c_op_halt) ? c_st_halted : c_st_fetch;
        end else if (w_abandon) begin
          w_state_next = c_st_fetch;
        end else begin
          w_state_next = c_st_exec;
        end
      end
      c_st_halted: begin
        // Only reset leaves HALTED.
        w_state_next = c_st_halted;
      end
      default: begin
        w_state_next = c_st_fetch;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: output logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_sm      = 1'b0;
    w_op_hot  = 16'h0000;
    w_io_wait = 1'b0;
    w_halted  = 1'b0;
    case (r_state)
      c_st_fetch: begin
        w_sm = 1'b0;
      end
      c_st_exec: begin
        w_sm = 1'b1;
        if (w_issue) begin
          w_op_hot = 16'h0001 << w_opcode;
        end else if (w_abandon) begin
          // The skipped I/O instruction is replaced by a NOP pulse.
          w_op_hot = c_hot_nop;
        end else begin
          // All-zero op_hot with sm = 1 tells the generator to do nothing.
          w_io_wait = 1'b1;
        end
      end
      c_st_halted: begin
        w_sm     = 1'b1;
        w_op_hot = c_hot_halt;
        w_halted = 1'b1;
      end
      default: begin
        w_sm = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Instruction register, flags, wait counter, timeout latch
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ir         <= 8'h00;
      r_z          <= 1'b0;
      r_c          <= 1'b0;
      r_io_timeout <= 1'b0;
      r_wait_cnt   <= 16'h0000;
    end else begin
      if (r_state == c_st_fetch) begin
        r_ir <= bus.bus_in;
      end

      // Flags load only at the end of a cycle that pulses an op_hot line,
      // so stall, FETCH and HALTED cycles never disturb them.
      if (w_issue || w_abandon) begin
        if (bus.cf_en) begin
          r_c <= bus.alu_cf;
        end
        if (bus.zf_en) begin
          r_z <= bus.alu_zf;
        end
      end

      if (w_stall) begin
        r_wait_cnt <= r_wait_cnt + 16'h0001;
      end else begin
        r_wait_cnt <= 16'h0000;
      end

      if (w_abandon) begin
        r_io_timeout <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign bus.ir         = r_ir;
  assign bus.sm         = w_sm;
  assign bus.op_hot     = w_op_hot;
  assign bus.z          = r_z;
  assign bus.c          = r_c;
  assign bus.io_wait    = w_io_wait;
  assign bus.halted     = w_halted;
  assign bus.io_timeout = r_io_timeout;

endmodule
`default_nettype wire

// File: tb/tb_seq_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_decoder
//  Description : Directed self-checking bench for seq_decoder (IO_TIMEOUT=4).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_decoder;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  seq_decoder_if bus_if ();

  seq_decoder #(
    .IO_TIMEOUT (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Checks every reset value visible at the ports.
  task automatic check_reset(input string tag);
    check({tag, "_sm"},      16'(bus_if.sm),         16'h0);
    check({tag, "_op_hot"},  bus_if.op_hot,          16'h0000);
    check({tag, "_ir"},      16'(bus_if.ir),         16'h0000);
    check({tag, "_z"},       16'(bus_if.z),          16'h0);
    check({tag, "_c"},       16'(bus_if.c),          16'h0);
    check({tag, "_io_wait"}, 16'(bus_if.io_wait),    16'h0);
    check({tag, "_halted"},  16'(bus_if.halted),     16'h0);
    check({tag, "_io_to"},   16'(bus_if.io_timeout), 16'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst_n            = 1'b0;
    bus_if.bus_in    = 8'h00;
    bus_if.alu_cf    = 1'b0;
    bus_if.alu_zf    = 1'b0;
    bus_if.cf_en     = 1'b0;
    bus_if.zf_en     = 1'b0;
    bus_if.in_valid  = 1'b0;
    bus_if.out_ready = 1'b0;

    // ---------------- Reset ----------------
    tick();
    tick();
    check_reset("rst");

    // ---------------- ADD 8'h60, flags load ----------------
    rst_n         = 1'b1;
    bus_if.bus_in = 8'h60;
    bus_if.alu_cf = 1'b1;
    bus_if.alu_zf = 1'b0;
    bus_if.cf_en  = 1'b1;
    bus_if.zf_en  = 1'b1;
    #1;
    check("add_fetch_sm", 16'(bus_if.sm), 16'h0);
    check("add_fetch_hot", bus_if.op_hot, 16'h0000);
    check("add_fetch_c_ignored", 16'(bus_if.c), 16'h0);
    tick();
    check("add_exec_sm", 16'(bus_if.sm), 16'h1);
    check("add_exec_hot", bus_if.op_hot, 16'h0040);
    check("add_exec_ir", 16'(bus_if.ir), 16'h0060);
    tick();
    check("add_done_sm", 16'(bus_if.sm), 16'h0);
    check("add_done_c", 16'(bus_if.c), 16'h1);
    check("add_done_z", 16'(bus_if.z), 16'h0);

    // ---------------- IN 8'h14 with 3 stall cycles ----------------
    bus_if.cf_en    = 1'b0;
    bus_if.zf_en    = 1'b0;
    bus_if.bus_in   = 8'h14;
    bus_if.in_valid = 1'b0;
    tick();
    for (int i = 0; i < 3; i++) begin
      check("in_stall_wait", 16'(bus_if.io_wait), 16'h1);
      check("in_stall_hot", bus_if.op_hot, 16'h0000);
      check("in_stall_sm", 16'(bus_if.sm), 16'h1);
      tick();
    end
    bus_if.in_valid = 1'b1;
    #1;
    check("in_done_hot", bus_if.op_hot, 16'h0002);
    check("in_done_wait", 16'(bus_if.io_wait), 16'h0);
    tick();
    check("in_after_sm", 16'(bus_if.sm), 16'h0);
    bus_if.in_valid = 1'b0;

    // ---------------- OUT with handshake already high: zero stall ----------------
    bus_if.bus_in    = 8'h20;
    bus_if.out_ready = 1'b1;
    tick();
    check("out_fast_hot", bus_if.op_hot, 16'h0004);
    check("out_fast_wait", 16'(bus_if.io_wait), 16'h0);
    tick();
    check("out_fast_after_sm", 16'(bus_if.sm), 16'h0);

    // ---------------- OUT timeout (IO_TIMEOUT = 4) ----------------
    bus_if.out_ready = 1'b0;
    bus_if.bus_in    = 8'h20;
    tick();
    // Flag enables during stall cycles must be ignored (c is 1 here).
    bus_if.cf_en  = 1'b1;
    bus_if.alu_cf = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("out_to_stall_wait", 16'(bus_if.io_wait), 16'h1);
      check("out_to_stall_hot", bus_if.op_hot, 16'h0000);
      tick();
    end
    bus_if.cf_en = 1'b0;
    #1;
    check("out_to_nop_hot", bus_if.op_hot, 16'h0001);
    check("out_to_nop_wait", 16'(bus_if.io_wait), 16'h0);
    check("out_to_not_yet", 16'(bus_if.io_timeout), 16'h0);
    tick();
    check("out_to_after_sm", 16'(bus_if.sm), 16'h0);
    check("out_to_sticky", 16'(bus_if.io_timeout), 16'h1);
    check("stall_c_held", 16'(bus_if.c), 16'h1);

    // ---------------- Flag hold: SUB sets z, MOVA keeps it, JZ ----------------
    bus_if.bus_in = 8'h70;
    bus_if.zf_en  = 1'b1;
    bus_if.alu_zf = 1'b1;
    tick();
    check("sub_hot", bus_if.op_hot, 16'h0080);
    tick();
    check("sub_z", 16'(bus_if.z), 16'h1);
    bus_if.bus_in = 8'h30;
    bus_if.zf_en  = 1'b0;
    bus_if.cf_en  = 1'b0;
    bus_if.alu_zf = 1'b0;
    tick();
    check("mova_hot", bus_if.op_hot, 16'h0008);
    tick();
    check("mova_z_held", 16'(bus_if.z), 16'h1);
    check("mova_c_held", 16'(bus_if.c), 16'h1);
    bus_if.bus_in = 8'hD0;
    tick();
    check("jz_hot", bus_if.op_hot, 16'h2000);
    check("jz_io_to_sticky", 16'(bus_if.io_timeout), 16'h1);
    tick();

    // ---------------- HALT ----------------
    bus_if.bus_in = 8'hF0;
    tick();
    check("halt_exec_hot", bus_if.op_hot, 16'h8000);
    check("halt_exec_halted", 16'(bus_if.halted), 16'h0);
    tick();
    bus_if.bus_in   = 8'h60;
    bus_if.in_valid = 1'b1;
    bus_if.cf_en    = 1'b1;
    bus_if.alu_cf   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("halted_flag", 16'(bus_if.halted), 16'h1);
      check("halted_sm", 16'(bus_if.sm), 16'h1);
      check("halted_hot", bus_if.op_hot, 16'h8000);
      tick();
    end
    check("halted_c_held", 16'(bus_if.c), 16'h1);
    check("halted_ir", 16'(bus_if.ir), 16'h00F0);
    rst_n           = 1'b0;
    bus_if.cf_en    = 1'b0;
    bus_if.in_valid = 1'b0;
    tick();
    check_reset("halt_rst");

    // ---------------- Reset in the middle of an IN stall ----------------
    rst_n         = 1'b1;
    bus_if.bus_in = 8'h14;
    tick();
    check("mid_stall_wait", 16'(bus_if.io_wait), 16'h1);
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    check("mid_rst_sm", 16'(bus_if.sm), 16'h0);
    check("mid_rst_wait", 16'(bus_if.io_wait), 16'h0);
    check("mid_rst_ir", 16'(bus_if.ir), 16'h0000);
    // Wait counter restarts from 0: a fresh IN stalls exactly 4 cycles.
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      check("post_rst_stall", 16'(bus_if.io_wait), 16'h1);
      tick();
    end
    check("post_rst_to_hot", bus_if.op_hot, 16'h0001);
    tick();
    check("post_rst_to_flag", 16'(bus_if.io_timeout), 16'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
